// File: rtl/j83_ts_rd_ctrl_if.sv
// Read-request and framed-byte handshake between the J.83 read controller and its neighbours.
// The master is the controller. The slave is the TS mux and framer side.
interface j83_ts_rd_ctrl_if;
    logic       ts_rd_sync;
    logic       ts_rd_req;
    logic [7:0] ts_in;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_sop;

    modport master (
        output ts_rd_sync, ts_rd_req, byte_out, byte_valid, byte_sop,
        input  ts_in
    );

    modport slave (
        input  ts_rd_sync, ts_rd_req, byte_out, byte_valid, byte_sop,
        output ts_in
    );
endinterface

// File: rtl/j83_ts_rd_ctrl.sv
// NCO-paced TS byte reader for the J.83 framer.
// Issues packet-aligned read strobes, captures the returned bytes and applies Annex A/C sync inversion.
module j83_ts_rd_ctrl #(
    parameter int U_DLY   = 1,
    parameter int RD_LAT  = 1,
    parameter int PKT_LEN = 188,
    parameter int NCO_W   = 24
) (
    input  logic                 clk_125m,
    input  logic                 rst_125m,
    input  logic                 enable,
    input  logic [NCO_W-1:0]     rate_word,
    j83_ts_rd_ctrl_if.master     bus,
    output logic [15:0]          sync_err_cnt,
    output logic [31:0]          pkt_cnt
);
    localparam int CNT_W = $clog2(PKT_LEN);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [NCO_W-1:0] acc, acc_nxt;
    logic             tick;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic             req_nxt, sync_nxt;
    logic [RD_LAT-1:0] req_pipe, sync_pipe;
    logic             tail_req, tail_sync;
    logic [2:0]       pkt_idx;
    logic [31:0]      unused_dly;

    // The unit delay only ever shaped simulation timing; it has no effect on logic.
    assign unused_dly = U_DLY;

    assign {tick, acc_nxt} = {1'b0, acc} + {1'b0, rate_word};

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        req_nxt      = 1'b0;
        sync_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (tick && enable) begin
                    req_nxt      = 1'b1;
                    sync_nxt     = 1'b1;
                    byte_cnt_nxt = CNT_W'(1);
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    req_nxt = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        byte_cnt_nxt = byte_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_125m) begin
        if (rst_125m) begin
            state          <= IDLE;
            acc            <= '0;
            byte_cnt       <= '0;
            bus.ts_rd_req  <= 1'b0;
            bus.ts_rd_sync <= 1'b0;
        end else begin
            state          <= state_nxt;
            acc            <= acc_nxt;
            byte_cnt       <= byte_cnt_nxt;
            bus.ts_rd_req  <= req_nxt;
            bus.ts_rd_sync <= sync_nxt;
        end
    end

    // Tail of the pipe lines up with the cycle in which ts_in carries the requested byte.
    assign tail_req  = req_pipe[RD_LAT-1];
    assign tail_sync = sync_pipe[RD_LAT-1];

    always_ff @(posedge clk_125m) begin
        if (rst_125m) begin
            req_pipe       <= '0;
            sync_pipe      <= '0;
            bus.byte_out   <= '0;
            bus.byte_valid <= 1'b0;
            bus.byte_sop   <= 1'b0;
            pkt_idx        <= '0;
            sync_err_cnt   <= '0;
            pkt_cnt        <= '0;
        end else begin
            req_pipe       <= RD_LAT'({req_pipe, bus.ts_rd_req});
            sync_pipe      <= RD_LAT'({sync_pipe, bus.ts_rd_sync});
            bus.byte_valid <= tail_req;
            bus.byte_sop   <= tail_req & tail_sync;
            if (tail_req) begin
                if (tail_sync) begin
                    bus.byte_out <= (pkt_idx == 3'd0) ? 8'hB8 : 8'h47;
                    pkt_idx      <= pkt_idx + 3'd1;
                    pkt_cnt      <= pkt_cnt + 32'd1;
                    if (bus.ts_in != 8'h47 && sync_err_cnt != 16'hFFFF)
                        sync_err_cnt <= sync_err_cnt + 16'd1;
                end else begin
                    bus.byte_out <= bus.ts_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_j83_ts_rd_ctrl.sv
// Bench for j83_ts_rd_ctrl: a cycle scoreboard built from the NCO/packet rules plus per-scenario tasks.
module tb_j83_ts_rd_ctrl;
    localparam int     RD_LAT  = 3;
    localparam int     PKT_LEN = 188;
    localparam int     NCO_W   = 24;
    localparam longint NCO_MOD = longint'(1) << NCO_W;

    logic             clk_125m = 1'b0;
    logic             rst_125m = 1'b1;
    logic             enable   = 1'b0;
    logic [NCO_W-1:0] rate_word = '0;
    logic [15:0]      sync_err_cnt;
    logic [31:0]      pkt_cnt;

    j83_ts_rd_ctrl_if bus ();

    j83_ts_rd_ctrl #(
        .U_DLY   (1),
        .RD_LAT  (RD_LAT),
        .PKT_LEN (PKT_LEN),
        .NCO_W   (NCO_W)
    ) dut (
        .clk_125m     (clk_125m),
        .rst_125m     (rst_125m),
        .enable       (enable),
        .rate_word    (rate_word),
        .bus          (bus),
        .sync_err_cnt (sync_err_cnt),
        .pkt_cnt      (pkt_cnt)
    );

    always #4 clk_125m = ~clk_125m;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [7:0]  b;
        logic        sop;
        logic [31:0] pcnt;
        logic [15:0] err;
    } exp_t;

    exp_t             exq[$];
    int               cyc = 0;
    longint           m_acc = 0;
    int               m_n = 0;
    int               m_pkts = 0;
    logic [15:0]      m_err = '0;
    int               bad_pkt = -1;
    bit               bad_all = 1'b0;
    logic             prev_rst = 1'b1;
    logic             prev_en = 1'b0;
    logic [NCO_W-1:0] prev_rate = '0;
    logic [7:0]       line [0:RD_LAT];

    // Reference: byte tick whenever the phase wraps; a packet is PKT_LEN consecutive ticks starting
    // only if enable was high; the mux answers RD_LAT cycles later; output appears one cycle after.
    initial begin
        exp_t       e;
        logic       exp_req, exp_sync;
        logic [7:0] src;
        for (int i = 0; i <= RD_LAT; i++) line[i] = 8'h00;
        bus.ts_in = 8'h00;
        forever begin
            @(negedge clk_125m);
            cyc++;
            exp_req  = 1'b0;
            exp_sync = 1'b0;
            if (prev_rst) begin
                m_acc  = 0;
                m_n    = 0;
                m_pkts = 0;
                m_err  = '0;
                exq.delete();
            end else begin
                m_acc = m_acc + prev_rate;
                if (m_acc >= NCO_MOD) begin
                    m_acc   = m_acc - NCO_MOD;
                    exp_req = (m_n != 0) || prev_en;
                end
                exp_sync = exp_req && (m_n == 0);
            end
            n_checks++;
            if (bus.ts_rd_req !== exp_req || bus.ts_rd_sync !== exp_sync) begin
                n_fail++;
                $display("FAIL req_strobe cyc=%0d req/sync actual=%b%b required=%b%b",
                         cyc, bus.ts_rd_req, bus.ts_rd_sync, exp_req, exp_sync);
            end
            src = 8'($urandom);
            if (exp_req) begin
                e.cyc = cyc + RD_LAT + 1;
                if (m_n == 0) begin
                    if (bad_all || m_pkts == bad_pkt) begin
                        src = 8'($urandom_range(255, 0));
                        if (src == 8'h47) src = 8'h00;
                    end else begin
                        src = 8'h47;
                    end
                    if (src != 8'h47 && m_err != 16'hFFFF) m_err = m_err + 16'd1;
                    e.b    = (m_pkts % 8 == 0) ? 8'hB8 : 8'h47;
                    e.sop  = 1'b1;
                    e.pcnt = 32'(m_pkts + 1);
                    e.err  = m_err;
                    m_pkts++;
                end else begin
                    e.b    = src;
                    e.sop  = 1'b0;
                    e.pcnt = '0;
                    e.err  = '0;
                end
                exq.push_back(e);
                m_n = (m_n == PKT_LEN - 1) ? 0 : m_n + 1;
            end
            for (int i = RD_LAT; i > 0; i--) line[i] = line[i-1];
            line[0]   = src;
            bus.ts_in = line[RD_LAT];

            if (exq.size() > 0 && exq[0].cyc == cyc) begin
                e = exq.pop_front();
                n_checks++;
                if (bus.byte_valid !== 1'b1 || bus.byte_out !== e.b || bus.byte_sop !== e.sop) begin
                    n_fail++;
                    $display("FAIL byte_stream cyc=%0d valid/sop/byte actual=%b/%b/%h required=1/%b/%h",
                             cyc, bus.byte_valid, bus.byte_sop, bus.byte_out, e.sop, e.b);
                end
                if (e.sop) begin
                    n_checks++;
                    if (pkt_cnt !== e.pcnt || sync_err_cnt !== e.err) begin
                        n_fail++;
                        $display("FAIL sop_counters cyc=%0d pkt_cnt/err actual=%0d/%h required=%0d/%h",
                                 cyc, pkt_cnt, sync_err_cnt, e.pcnt, e.err);
                    end
                end
            end else begin
                n_checks++;
                if (bus.byte_valid !== 1'b0 || bus.byte_sop !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_valid cyc=%0d valid/sop actual=%b/%b required=0/0",
                             cyc, bus.byte_valid, bus.byte_sop);
                end
            end
            if (prev_rst) begin
                n_checks++;
                if (bus.byte_out !== 8'h00 || pkt_cnt !== 32'd0 || sync_err_cnt !== 16'd0) begin
                    n_fail++;
                    $display("FAIL reset_outputs cyc=%0d byte/pkt/err actual=%h/%0d/%h required=00/0/0000",
                             cyc, bus.byte_out, pkt_cnt, sync_err_cnt);
                end
            end
            prev_rst  = rst_125m;
            prev_en   = enable;
            prev_rate = rate_word;
        end
    end

    task automatic tick_c();
        @(posedge clk_125m);
        #1;
    endtask

    task automatic do_reset();
        rst_125m  = 1'b1;
        enable    = 1'b0;
        rate_word = '0;
        bad_all   = 1'b0;
        bad_pkt   = -1;
        repeat (4) tick_c();
        rst_125m = 1'b0;
    endtask

    task automatic test_reset();
        int nreq;
        do_reset();
        n_checks++;
        if (bus.ts_rd_req !== 1'b0 || bus.ts_rd_sync !== 1'b0 || bus.byte_valid !== 1'b0 ||
            bus.byte_sop !== 1'b0 || bus.byte_out !== 8'h00 || pkt_cnt !== 32'd0 || sync_err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state req/sync/valid/sop/byte/pkt/err actual=%b%b%b%b/%h/%0d/%h required=0000/00/0/0000",
                     bus.ts_rd_req, bus.ts_rd_sync, bus.byte_valid, bus.byte_sop, bus.byte_out, pkt_cnt, sync_err_cnt);
        end
        rate_word = 24'hFFFFFF;
        nreq = 0;
        repeat (50) begin
            tick_c();
            if (bus.ts_rd_req) nreq++;
        end
        n_checks++;
        if (nreq != 0) begin
            n_fail++;
            $display("FAIL disabled_ticks requests actual=%0d required=0", nreq);
        end
    endtask

    task automatic test_basic_rate();
        int c, ridx, first_req, first_val, prev_req, bad_gap;
        int sync_at[$];
        logic first_sop;
        do_reset();
        enable    = 1'b1;
        rate_word = 24'h800000;
        c = 0; ridx = 0; first_req = -1; first_val = -1; prev_req = -1; bad_gap = 0; first_sop = 1'b0;
        while (sync_at.size() < 3 && c < 2000) begin
            tick_c();
            c++;
            if (bus.ts_rd_req) begin
                if (first_req < 0) first_req = c;
                if (prev_req >= 0 && c - prev_req != 2) bad_gap++;
                prev_req = c;
                if (bus.ts_rd_sync) sync_at.push_back(ridx);
                ridx++;
            end
            if (bus.byte_valid && first_val < 0) begin
                first_val = c;
                first_sop = bus.byte_sop;
            end
        end
        n_checks++;
        if (sync_at.size() != 3 || sync_at[0] != 0 || sync_at[1] != 188 || sync_at[2] != 376) begin
            n_fail++;
            $display("FAIL sync_positions count=%0d actual=%p required=0,188,376", sync_at.size(), sync_at);
        end
        n_checks++;
        if (bad_gap != 0) begin
            n_fail++;
            $display("FAIL half_rate_gaps irregular gaps actual=%0d required=0", bad_gap);
        end
        n_checks++;
        if (first_val - first_req != RD_LAT + 1 || first_sop !== 1'b1) begin
            n_fail++;
            $display("FAIL first_latency latency/sop actual=%0d/%b required=%0d/1",
                     first_val - first_req, first_sop, RD_LAT + 1);
        end
    endtask

    task automatic test_payload();
        int c, nsync, b8, s47;
        do_reset();
        enable    = 1'b1;
        rate_word = NCO_W'($urandom_range(32'hFFFFFF, 32'h600000));
        c = 0; nsync = 0; b8 = 0; s47 = 0;
        while (nsync < 16 && c < 20000) begin
            tick_c();
            c++;
            if (bus.ts_rd_sync) nsync++;
            if (bus.byte_valid && bus.byte_sop) begin
                if (bus.byte_out == 8'hB8) b8++;
                if (bus.byte_out == 8'h47) s47++;
            end
        end
        enable = 1'b0;
        repeat (700) begin
            tick_c();
            if (bus.byte_valid && bus.byte_sop) begin
                if (bus.byte_out == 8'hB8) b8++;
                if (bus.byte_out == 8'h47) s47++;
            end
        end
        n_checks++;
        if (nsync != 16 || pkt_cnt !== 32'd16 || sync_err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL sixteen_packets sync/pkt/err actual=%0d/%0d/%h required=16/16/0000",
                     nsync, pkt_cnt, sync_err_cnt);
        end
        n_checks++;
        if (b8 != 2 || s47 != 14) begin
            n_fail++;
            $display("FAIL sync_inversion B8/47 count actual=%0d/%0d required=2/14", b8, s47);
        end
    endtask

    task automatic run_packets(input int npkt);
        int c, nsync;
        enable = 1'b1;
        c = 0; nsync = 0;
        while (nsync < npkt && c < 5000) begin
            tick_c();
            c++;
            if (bus.ts_rd_sync) nsync++;
        end
        enable = 1'b0;
        repeat (500) tick_c();
        n_checks++;
        if (nsync != npkt) begin
            n_fail++;
            $display("FAIL packet_start sync strobes actual=%0d required=%0d", nsync, npkt);
        end
    endtask

    task automatic test_sync_err();
        int c, nsop;
        logic [7:0] sop3;
        do_reset();
        bad_pkt   = 3;
        rate_word = 24'h800000;
        enable    = 1'b1;
        c = 0; nsop = 0; sop3 = 8'h00;
        while (nsop < 5 && c < 5000) begin
            tick_c();
            c++;
            if (bus.byte_valid && bus.byte_sop) begin
                if (nsop == 3) sop3 = bus.byte_out;
                nsop++;
                if (nsop == 5) enable = 1'b0;
            end
        end
        repeat (500) tick_c();
        n_checks++;
        if (sync_err_cnt !== 16'd1 || sop3 !== 8'h47 || pkt_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL bad_sync_byte err/byte/pkt actual=%h/%h/%0d required=0001/47/5",
                     sync_err_cnt, sop3, pkt_cnt);
        end
        force dut.sync_err_cnt = 16'hFFFD;
        #1;
        release dut.sync_err_cnt;
        m_err   = 16'hFFFD;
        bad_pkt = -1;
        bad_all = 1'b1;
        run_packets(4);
        n_checks++;
        if (sync_err_cnt !== 16'hFFFF || pkt_cnt !== 32'd9) begin
            n_fail++;
            $display("FAIL err_saturate err/pkt actual=%h/%0d required=FFFF/9", sync_err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_rate_change();
        int c, nreq, r_fast, s_fast, r_zero, tot;
        bit done;
        do_reset();
        enable    = 1'b1;
        rate_word = 24'h800000;
        c = 0; nreq = 0;
        while (nreq < 60 && c < 1000) begin
            tick_c();
            c++;
            if (bus.ts_rd_req) nreq++;
        end
        rate_word = 24'hFFFFFF;
        r_fast = 0; s_fast = 0;
        repeat (50) begin
            tick_c();
            if (bus.ts_rd_req) r_fast++;
            if (bus.ts_rd_sync) s_fast++;
        end
        rate_word = '0;
        r_zero = 0;
        repeat (100) begin
            tick_c();
            if (bus.ts_rd_req || bus.ts_rd_sync) r_zero++;
        end
        n_checks++;
        if (r_fast < 49 || s_fast != 0 || r_zero != 0) begin
            n_fail++;
            $display("FAIL rate_extremes fast_req/fast_sync/zero_req actual=%0d/%0d/%0d required=>=49/0/0",
                     r_fast, s_fast, r_zero);
        end
        rate_word = 24'h800000;
        tot = nreq + r_fast;
        c = 0; done = 1'b0;
        while (!done && c < 1000) begin
            tick_c();
            c++;
            if (bus.ts_rd_sync) done = 1'b1;
            else if (bus.ts_rd_req) tot++;
        end
        enable = 1'b0;
        n_checks++;
        if (!done || tot != PKT_LEN) begin
            n_fail++;
            $display("FAIL resume_count next_sync/bytes actual=%b/%0d required=1/%0d", done, tot, PKT_LEN);
        end
        repeat (500) tick_c();
    endtask

    task automatic test_enable_drop();
        int c, nreq, after, s_after;
        bit seen;
        do_reset();
        enable    = 1'b1;
        rate_word = NCO_W'($urandom_range(32'hFFFFFF, 32'h800000));
        c = 0; nreq = 0;
        while (nreq < 51 && c < 1000) begin
            tick_c();
            c++;
            if (bus.ts_rd_req) nreq++;
        end
        enable = 1'b0;
        after = 0; s_after = 0;
        repeat (600) begin
            tick_c();
            if (bus.ts_rd_req) after++;
            if (bus.ts_rd_sync) s_after++;
        end
        n_checks++;
        if (nreq != 51 || after != PKT_LEN - 51 || s_after != 0) begin
            n_fail++;
            $display("FAIL enable_drop before/after/sync actual=%0d/%0d/%0d required=51/%0d/0",
                     nreq, after, s_after, PKT_LEN - 51);
        end
        enable = 1'b1;
        seen = 1'b0;
        c = 0;
        while (!seen && c < 20) begin
            tick_c();
            c++;
            if (bus.ts_rd_sync) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL enable_resume sync within 20 cycles actual=0 required=1");
        end
        enable = 1'b0;
        repeat (500) tick_c();
    endtask

    task automatic test_reset_mid();
        int c, nreq;
        bit got;
        logic [7:0] fb;
        logic fsop;
        logic [31:0] fpkt;
        do_reset();
        enable    = 1'b1;
        rate_word = 24'h800000;
        c = 0; nreq = 0;
        while (nreq < 101 && c < 1000) begin
            tick_c();
            c++;
            if (bus.ts_rd_req) nreq++;
        end
        rst_125m = 1'b1;
        tick_c();
        n_checks++;
        if (bus.ts_rd_req !== 1'b0 || bus.ts_rd_sync !== 1'b0 || bus.byte_valid !== 1'b0 ||
            bus.byte_sop !== 1'b0 || bus.byte_out !== 8'h00 || pkt_cnt !== 32'd0 || sync_err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset_drop req/sync/valid/sop/byte/pkt/err actual=%b%b%b%b/%h/%0d/%h required=0000/00/0/0000",
                     bus.ts_rd_req, bus.ts_rd_sync, bus.byte_valid, bus.byte_sop, bus.byte_out, pkt_cnt, sync_err_cnt);
        end
        tick_c();
        rst_125m = 1'b0;
        got = 1'b0; c = 0; fb = 8'h00; fsop = 1'b0; fpkt = '0;
        while (!got && c < 100) begin
            tick_c();
            c++;
            if (bus.byte_valid) begin
                got  = 1'b1;
                fb   = bus.byte_out;
                fsop = bus.byte_sop;
                fpkt = pkt_cnt;
            end
        end
        n_checks++;
        if (!got || fb !== 8'hB8 || fsop !== 1'b1 || fpkt !== 32'd1) begin
            n_fail++;
            $display("FAIL restart_first_byte seen/byte/sop/pkt actual=%b/%h/%b/%0d required=1/B8/1/1",
                     got, fb, fsop, fpkt);
        end
        enable = 1'b0;
        repeat (500) tick_c();
    endtask

    initial begin
        test_reset();
        test_basic_rate();
        test_payload();
        test_sync_err();
        test_rate_change();
        test_enable_drop();
        test_reset_mid();
        repeat (10) tick_c();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
